// File: rtl/iq_modulate.sv
// Differential-BPSK baseband modulator.
// Bytes arrive over a valid/ready handshake, are serialised LSB-first and
// emitted as pulse-shaped signed I/Q samples (5 samples per symbol, envelope
// weights 1,3,5,3,1), one sample per ce&&strobe_in tick.
// Frame: REF symbol, PREAMBLE_BITS inverting symbols, 8 symbols per byte,
// one TAIL symbol.
module iq_modulate #(
  parameter int DATA_WIDTH    = 16,
  parameter int I_UNIT        = -6,
  parameter int Q_UNIT        = 8,
  parameter int PREAMBLE_BITS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         ce,
  input  logic                         strobe_in,
  input  logic [7:0]                   tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  output logic signed [DATA_WIDTH-1:0] I_out,
  output logic signed [DATA_WIDTH-1:0] Q_out,
  output logic                         strobe_out,
  output logic                         busy,
  output logic [6:0]                   bits_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REF  = 3'd1,
    S_PRE  = 3'd2,
    S_DATA = 3'd3,
    S_TAIL = 3'd4
  } state_t;

  localparam logic signed [DATA_WIDTH-1:0] C_I_UNIT   = DATA_WIDTH'(I_UNIT);
  localparam logic signed [DATA_WIDTH-1:0] C_Q_UNIT   = DATA_WIDTH'(Q_UNIT);
  localparam logic [3:0]                   C_PRE_LAST = 4'(PREAMBLE_BITS - 1);

  state_t                         r_state;
  state_t                         w_state_next;
  logic [2:0]                     r_k;          // sample index within symbol, 0..4
  logic                           r_sign;       // 1 = negative phasor
  logic [3:0]                     r_pre_cnt;
  logic [2:0]                     r_bit_idx;
  logic [7:0]                     r_shift;
  logic [7:0]                     r_hold;
  logic                           r_hold_full;
  logic [6:0]                     r_bits_count;
  logic signed [DATA_WIDTH-1:0]   r_i_out;
  logic signed [DATA_WIDTH-1:0]   r_q_out;
  logic                           r_strobe;
  logic                           r_busy;

  logic                           w_tick;
  logic                           w_sym_end;
  logic                           w_start;
  logic                           w_pre_last;
  logic                           w_data_last;
  logic                           w_load_shift;
  logic                           w_accept;
  logic                           w_active;
  logic                           w_sign_eff;
  logic [2:0]                     w_weight;
  logic signed [DATA_WIDTH-1:0]   w_i_mag;
  logic signed [DATA_WIDTH-1:0]   w_q_mag;
  logic signed [DATA_WIDTH-1:0]   w_i_next;
  logic signed [DATA_WIDTH-1:0]   w_q_next;

  assign w_tick       = ce & strobe_in;
  assign w_sym_end    = w_tick && (r_k == 3'd4);
  assign w_start      = w_tick && (r_state == S_IDLE) && r_hold_full;
  assign w_pre_last   = (r_pre_cnt == C_PRE_LAST);
  assign w_data_last  = (r_bit_idx == 3'd7);
  // The hold register is drained into the shift register at the end of the
  // preamble and at the end of every byte, provided a byte is waiting.
  assign w_load_shift = w_sym_end && r_hold_full &&
                        (((r_state == S_PRE) && w_pre_last) ||
                         ((r_state == S_DATA) && w_data_last));
  // Acceptance looks at the registered hold flag, so a hold register that
  // empties this cycle only admits a new byte on a later cycle.
  assign w_accept     = ce && tx_valid && !r_hold_full;

  // Next-state logic: advances only at symbol boundaries, except IDLE exit.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start) w_state_next = S_REF;
      S_REF:  if (w_sym_end) w_state_next = S_PRE;
      S_PRE:  if (w_sym_end && w_pre_last)
                w_state_next = r_hold_full ? S_DATA : S_TAIL;
      S_DATA: if (w_sym_end && w_data_last && !r_hold_full)
                w_state_next = S_TAIL;
      S_TAIL: if (w_sym_end) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output logic: phase decision for this tick and shaped I/Q sample values.
  always_comb begin
    w_weight = 3'd1;
    case (r_k)
      3'd1, 3'd3: w_weight = 3'd3;
      3'd2:       w_weight = 3'd5;
      default:    w_weight = 3'd1;
    endcase

    // Phase changes take effect from the first sample of a symbol.
    w_sign_eff = r_sign;
    if (r_state == S_IDLE) begin
      w_sign_eff = 1'b0;
    end else if (r_k == 3'd0) begin
      if (r_state == S_PRE)       w_sign_eff = ~r_sign;
      else if (r_state == S_DATA) w_sign_eff = r_sign ^ r_shift[r_bit_idx];
    end

    w_active = (r_state != S_IDLE) || w_start;
    w_i_mag  = C_I_UNIT * $signed({{(DATA_WIDTH-3){1'b0}}, w_weight});
    w_q_mag  = C_Q_UNIT * $signed({{(DATA_WIDTH-3){1'b0}}, w_weight});
    w_i_next = '0;
    w_q_next = '0;
    if (w_active) begin
      w_i_next = w_sign_eff ? -w_i_mag : w_i_mag;
      w_q_next = w_sign_eff ? -w_q_mag : w_q_mag;
    end
  end

  // State register and registered busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else if (w_tick) begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  // Datapath: byte holding, symbol counters, phase and sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k          <= 3'd0;
      r_sign       <= 1'b0;
      r_pre_cnt    <= 4'd0;
      r_bit_idx    <= 3'd0;
      r_shift      <= 8'd0;
      r_hold       <= 8'd0;
      r_hold_full  <= 1'b0;
      r_bits_count <= 7'd0;
      r_i_out      <= '0;
      r_q_out      <= '0;
      r_strobe     <= 1'b0;
    end else begin
      // Strobe marks the cycle after a tick; with ce low there is no tick.
      r_strobe <= w_tick;

      if (w_load_shift) begin
        r_shift     <= r_hold;
        r_hold_full <= 1'b0;
      end else if (w_accept) begin
        r_hold      <= tx_data;
        r_hold_full <= 1'b1;
      end

      if (w_tick) begin
        r_i_out <= w_i_next;
        r_q_out <= w_q_next;
        r_sign  <= w_sign_eff;

        if (!w_active) r_k <= 3'd0;
        else           r_k <= (r_k == 3'd4) ? 3'd0 : r_k + 3'd1;

        if (w_start) r_bits_count <= 7'd0;

        if (w_sym_end) begin
          case (r_state)
            S_REF: r_pre_cnt <= 4'd0;
            S_PRE: begin
              r_pre_cnt <= r_pre_cnt + 4'd1;
              r_bit_idx <= 3'd0;
            end
            S_DATA: begin
              r_bits_count <= r_bits_count + 7'd1;
              r_bit_idx    <= r_bit_idx + 3'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign tx_ready   = !r_hold_full;
  assign I_out      = r_i_out;
  assign Q_out      = r_q_out;
  assign strobe_out = r_strobe;
  assign busy       = r_busy;
  assign bits_count = r_bits_count;

endmodule

// File: tb/tb_iq_modulate.sv
// Scoreboard bench for iq_modulate (PREAMBLE_BITS=2, unit phasor (-6,8)).
// Stimulus pushes hand-derived sample sequences into a queue; a monitor pops
// and compares on every strobe_out.
module tb_iq_modulate;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        strobe_in;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic signed [15:0] I_out;
  logic signed [15:0] Q_out;
  logic        strobe_out;
  logic        busy;
  logic [6:0]  bits_count;

  iq_modulate #(
    .DATA_WIDTH(16),
    .I_UNIT(-6),
    .Q_UNIT(8),
    .PREAMBLE_BITS(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ce(ce),
    .strobe_in(strobe_in),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .I_out(I_out),
    .Q_out(Q_out),
    .strobe_out(strobe_out),
    .busy(busy),
    .bits_count(bits_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int i;
    int q;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   acc_cnt = 0;

  // Positive-phasor shaped samples, hand-computed: W*(-6), W*8 for W=1,3,5,3,1.
  localparam int I_TAB [5] = '{-6, -18, -30, -18, -6};
  localparam int Q_TAB [5] = '{8, 24, 40, 24, 8};

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  function automatic int smp_i(input logic [31:0] pat, input int s);
    return pat[s / 5] ? -I_TAB[s % 5] : I_TAB[s % 5];
  endfunction

  function automatic int smp_q(input logic [31:0] pat, input int s);
    return pat[s / 5] ? -Q_TAB[s % 5] : Q_TAB[s % 5];
  endfunction

  // pat bit n = 1 means symbol n is transmitted with negative phase.
  task automatic push_samples(input logic [31:0] pat, input int n);
    exp_t e;
    for (int s = 0; s < n; s++) begin
      e.i = smp_i(pat, s);
      e.q = smp_q(pat, s);
      exp_q.push_back(e);
    end
  endtask

  task automatic push_zeros(input int n);
    exp_t e;
    e.i = 0;
    e.q = 0;
    for (int s = 0; s < n; s++) exp_q.push_back(e);
  endtask

  task automatic do_tick(input int gap);
    @(negedge clk);
    strobe_in = 1'b1;
    @(negedge clk);
    strobe_in = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, output int waited);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    waited   = 0;
    while (!tx_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!tx_ready) check("accept_timeout", 0, 1);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Monitor: every strobe_out must match the next queued sample.
  always @(negedge clk) begin
    exp_t e;
    if (strobe_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("I_out", int'(I_out), e.i);
        check("Q_out", int'(Q_out), e.q);
      end
    end
  end

  // Counts handshakes that load the hold register.
  always @(posedge clk) begin
    if (!rst && ce && tx_valid && tx_ready) acc_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    int w2;
    int acc0;

    rst = 1'b1; ce = 1'b1; strobe_in = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;

    // Reset held for 100 cycles with ticks: no strobes, idle outputs.
    do_tick(50);
    do_tick(50);
    check("rst_tx_ready", int'(tx_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_strobe", int'(strobe_out), 0);
    check("rst_I", int'(I_out), 0);
    check("rst_bits", int'(bits_count), 0);
    @(negedge clk);
    rst = 1'b0;

    // Idle ticks produce zero samples.
    push_zeros(3);
    for (int t = 0; t < 3; t++) do_tick(50);
    check("idle_busy", int'(busy), 0);
    check("idle_tx_ready", int'(tx_ready), 1);

    // Single byte 0x01 with a 37-cycle ce-low pause mid-symbol.
    // Signs: REF +, PRE -,+, bit0 inverts -> -, bits1..7 and TAIL -.
    acc0 = acc_cnt;
    send_byte(8'h01, waited);
    push_samples(32'hFFA, 60);
    for (int t = 0; t < 60; t++) begin
      do_tick(4);
      if (t == 22) begin
        check("mid_busy", int'(busy), 1);
        check("mid_bits", int'(bits_count), 1);
        @(negedge clk);
        ce = 1'b0;
        for (int c = 0; c < 37; c++) begin
          strobe_in = (c % 4 == 1);
          @(negedge clk);
          if (strobe_out) check("ce_low_strobe", 1, 0);
        end
        strobe_in = 1'b0;
        check("ce_hold_I", int'(I_out), 30);
        check("ce_hold_Q", int'(Q_out), -40);
        check("ce_hold_bits", int'(bits_count), 1);
        ce = 1'b1;
      end
    end
    check("b01_bits", int'(bits_count), 8);
    check("b01_busy", int'(busy), 0);
    check("b01_acc", acc_cnt - acc0, 1);
    push_zeros(2);
    do_tick(4);
    do_tick(4);

    // Back-to-back 0xFF then 0x00; second byte waits with valid high.
    acc0 = acc_cnt;
    send_byte(8'hFF, waited);
    push_samples(32'h2AA, 100);
    fork
      send_byte(8'h00, w2);
      for (int t = 0; t < 100; t++) do_tick(16);
    join
    check("b2b_wait_ge200", int'(w2 >= 200), 1);
    check("b2b_acc", acc_cnt - acc0, 2);
    check("b2b_bits", int'(bits_count), 16);
    check("b2b_busy", int'(busy), 0);
    push_zeros(2);
    do_tick(4);
    do_tick(4);

    // Byte 0x0A, reset at sample k=2 of data bit 3.
    // Signs: REF +, PRE -,+, bit0 +, bit1 -, bit2 -, bit3 +.
    send_byte(8'h0A, waited);
    push_samples(32'h32, 33);
    for (int t = 0; t < 33; t++) do_tick(4);
    check("pre_rst_bits", int'(bits_count), 3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", int'(busy), 0);
    check("abort_I", int'(I_out), 0);
    check("abort_Q", int'(Q_out), 0);
    check("abort_tx_ready", int'(tx_ready), 1);
    check("abort_bits", int'(bits_count), 0);
    rst = 1'b0;

    // Fresh frame after abort starts with REF sign +1.
    send_byte(8'h01, waited);
    push_samples(32'hFFA, 60);
    for (int t = 0; t < 60; t++) do_tick(4);
    check("post_bits", int'(bits_count), 8);
    check("post_busy", int'(busy), 0);

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/iq_modulate.md
Name: iq_modulate

Overview:
- Transmit-side counterpart of iq_analyse: a differential-BPSK baseband modulator.
- Accepts bytes over a valid/ready handshake and serialises them LSB-first.
- Emits pulse-shaped signed I/Q samples, one per input sample strobe, in the format iq_analyse consumes: 5 samples per symbol, envelope weights 1,3,5,3,1.
- Sits between the host byte interface and the DAC/upconversion path.

Parameters:
DATA_WIDTH, 16, width of the signed I_out/Q_out samples.
I_UNIT, -6, signed I component of the unit-weight phasor.
Q_UNIT, 8, signed Q component of the unit-weight phasor.
PREAMBLE_BITS, 4, number of phase-inverting preamble symbols per frame (range 1..15).

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
ce  in  1  clock enable; when low, all state and outputs freeze and strobe_out=0.
strobe_in  in  1  sample-rate strobe, one-cycle pulse; each ce&&strobe_in cycle produces one sample.
tx_data  in  8  byte to transmit.
tx_valid  in  1  tx_data valid.
tx_ready  out  1  holding register empty (=!hold_full, registered state).
I_out  out  DATA_WIDTH  signed I sample.
Q_out  out  DATA_WIDTH  signed Q sample.
strobe_out  out  1  one-cycle pulse marking a new I_out/Q_out.
busy  out  1  high while a frame is in progress (state != IDLE).
bits_count  out  7  data bits sent in current frame, modulo 128.

Behaviour:
- Reset (synchronous, priority over ce): state=IDLE, I_out=Q_out=0, strobe_out=0, busy=0, bits_count=0, hold_full=0 (so tx_ready=1), sign=+1, sample index k=0. A reset mid-frame aborts the frame immediately.
- Byte acceptance: on any ce-high cycle with tx_valid && tx_ready, latch tx_data into the hold register and set hold_full. Acceptance is independent of strobe_in.
  - Same-cycle hold-empty plus new valid: not accepted. tx_ready is low that cycle; the byte is accepted on a later cycle.
- Sample tick: tick = ce && strobe_in. All symbol/state advancement happens only on a tick.
  - Sample index k counts 0..4. Symbol boundary occurs at k=4 -> 0.
- Output timing: on each tick, register I_out = sign*W[k]*I_UNIT and Q_out = sign*W[k]*Q_UNIT, with W = {1,3,5,3,1}. strobe_out is asserted on the cycle after the tick (1-cycle latency), otherwise 0.
  - In IDLE, ticks produce I_out=Q_out=0 and strobe_out still pulses.
- Arithmetic: products are at most 5*|UNIT|. Designs must keep them within DATA_WIDTH; no saturation logic. Negation is two's complement.
- State machine (transitions only on tick at k=4, except IDLE exit):
  - IDLE -> REF: on a tick with hold_full=1. sign=+1, bits_count=0, k=0. The first sample of REF is output on this same tick.
  - REF: one symbol, no inversion. At its end -> PRE, with preamble counter=0.
  - PRE: each symbol begins with sign inverted (sign applied from k=0 of that symbol). After PREAMBLE_BITS symbols -> DATA if hold_full (move hold to shift register, clear hold_full, bit index=0), else -> TAIL.
  - DATA: at the start of each bit symbol, sign ^= current bit (1 = invert, 0 = keep). At each symbol end, bits_count increments.
    - After bit 7: if hold_full, reload shift register from hold, clear hold_full, and continue DATA; else -> TAIL.
  - TAIL: one symbol, sign unchanged. At its end -> IDLE, I_out/Q_out return to 0 on subsequent ticks.
- busy = (state != IDLE), registered.
- ce low in any state: no tick and no acceptance; all registers hold; strobe_out=0.
- Frame length: (1 + PREAMBLE_BITS + 8*N + 1) symbols for N back-to-back bytes.

Test Plan:
- Reset then idle: rst high for 100 cycles, ticks every 50 cycles, no tx_valid -> I_out=Q_out=0, strobe_out pulses 1 cycle after each tick, tx_ready=1, busy=0.
- Single byte 0x01, PREAMBLE_BITS=2 -> 12 symbols (60 samples). REF samples are (-6,8), (-18,24), (-30,40), (-18,24), (-6,8). Preamble signs are -,+. Data bit0 inverts: peak (30,-40); bits 1..7 and TAIL keep the - sign. bits_count ends at 8, then busy=0.
- Back-to-back bytes 0xFF, 0x00 presented while busy -> second byte accepted once the first has moved to the shift register. 0xFF gives alternating peak signs over 8 symbols; 0x00 gives a constant sign. No gap between bytes; bits_count=16; one TAIL.
- ce toggling low for 37 cycles mid-symbol -> state frozen, strobe_out=0, output sequence identical to the ce-always-high run apart from the delay.
- rst asserted at sample k=2 of data bit 3 -> next cycle: IDLE, outputs 0, tx_ready=1, bits_count=0. A new byte then starts cleanly with REF sign +1.
- tx_valid held high with tx_ready low for 200 cycles -> no acceptance until tx_ready rises. The byte is accepted exactly once.
